// File: rtl/image_color_accum.sv
// Per-image R/G/B accumulator feeding the insert-sort stage: sums each channel over
// NUM_PIX pixels, picks the dominant channel and presents it once the sorter is free.
module image_color_accum #(
    parameter int unsigned PIX_W   = 8,
    parameter int unsigned NUM_PIX = 1024,
    parameter int unsigned NUM_IMG = 32,
    parameter int unsigned TOT_W   = 23,
    parameter int unsigned IDX_W   = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             pix_valid,
    input  logic [PIX_W-1:0] pix_r,
    input  logic [PIX_W-1:0] pix_g,
    input  logic [PIX_W-1:0] pix_b,
    output logic             pix_ready,
    input  logic             sort_busy,
    output logic [1:0]       color,
    output logic [TOT_W-1:0] total,
    output logic [IDX_W-1:0] index,
    output logic             in_valid,
    output logic             done
);

    localparam int unsigned CNT_W = (NUM_PIX > 1) ? $clog2(NUM_PIX) : 1;
    localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(NUM_PIX - 1);
    localparam logic [IDX_W-1:0] LAST_IMG = IDX_W'(NUM_IMG - 1);

    localparam logic [1:0] COL_R = 2'b00;
    localparam logic [1:0] COL_G = 2'b01;
    localparam logic [1:0] COL_B = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACCUM,
        S_DECIDE,
        S_EMIT,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic [TOT_W-1:0] r_sum_r;
    logic [TOT_W-1:0] r_sum_g;
    logic [TOT_W-1:0] r_sum_b;
    logic [CNT_W-1:0] r_pix_cnt;
    logic [1:0]       r_color;
    logic [TOT_W-1:0] r_total;
    logic [IDX_W-1:0] r_index;
    logic             r_in_valid;

    logic             w_accept;
    logic             w_issue;
    logic             w_frame_start;
    logic             w_img_clear;
    logic             w_pix_ready;
    logic             w_done;
    logic [1:0]       w_color;
    logic [TOT_W-1:0] w_total;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_pix_ready   = 1'b0;
        w_done        = 1'b0;
        w_accept      = 1'b0;
        w_issue       = 1'b0;
        w_frame_start = 1'b0;
        w_img_clear   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_frame_start = 1'b1;
                    w_state_nxt   = S_ACCUM;
                end
            end
            S_ACCUM: begin
                w_pix_ready = 1'b1;
                w_accept    = pix_valid;
                if (pix_valid && (r_pix_cnt == LAST_PIX)) begin
                    w_state_nxt = S_DECIDE;
                end
            end
            S_DECIDE: begin
                w_state_nxt = S_EMIT;
            end
            S_EMIT: begin
                if (!sort_busy) begin
                    w_issue     = 1'b1;
                    w_img_clear = 1'b1;
                    w_state_nxt = (r_index == LAST_IMG) ? S_DONE : S_ACCUM;
                end
            end
            S_DONE: begin
                w_done = 1'b1;
                if (start) begin
                    w_frame_start = 1'b1;
                    w_state_nxt   = S_ACCUM;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sum_r   <= '0;
            r_sum_g   <= '0;
            r_sum_b   <= '0;
            r_pix_cnt <= '0;
        end else if (w_frame_start || w_img_clear) begin
            r_sum_r   <= '0;
            r_sum_g   <= '0;
            r_sum_b   <= '0;
            r_pix_cnt <= '0;
        end else if (w_accept) begin
            r_sum_r   <= r_sum_r + TOT_W'(pix_r);
            r_sum_g   <= r_sum_g + TOT_W'(pix_g);
            r_sum_b   <= r_sum_b + TOT_W'(pix_b);
            r_pix_cnt <= r_pix_cnt + 1'b1;
        end
    end

    // Ties resolve toward the lower channel: R over G over B.
    always_comb begin
        w_color = COL_B;
        w_total = r_sum_b;
        if ((r_sum_r >= r_sum_g) && (r_sum_r >= r_sum_b)) begin
            w_color = COL_R;
            w_total = r_sum_r;
        end else if (r_sum_g >= r_sum_b) begin
            w_color = COL_G;
            w_total = r_sum_g;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_color <= '0;
            r_total <= '0;
        end else if (r_state == S_DECIDE) begin
            r_color <= w_color;
            r_total <= w_total;
        end
    end

    // Index advances after the strobe cycle so it names the issued image while
    // in_valid is high; it holds at the last image rather than wrapping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_index    <= '0;
            r_in_valid <= 1'b0;
        end else begin
            r_in_valid <= w_issue;
            if (w_frame_start) begin
                r_index <= '0;
            end else if (r_in_valid && (r_index != LAST_IMG)) begin
                r_index <= r_index + 1'b1;
            end
        end
    end

    assign pix_ready = w_pix_ready;
    assign done      = w_done;
    assign color     = r_color;
    assign total     = r_total;
    assign index     = r_index;
    assign in_valid  = r_in_valid;

endmodule
